// File: rtl/fadd_sched.sv
// fadd_sched: round-robin scheduler that shares one single-precision adder
// among N requesters. One operation is in flight at a time.
//
// Ports
//   clk, rstn           clock, synchronous active-low reset
//   req_valid/ready     per-requester request handshake (N bits each)
//   req_x1, req_x2      packed operands, requester i in bits [32i+31:32i]
//   req_sub             1 = x1 - x2, 0 = x1 + x2
//   resp_valid/ready    per-requester response handshake (N bits each)
//   resp_y, resp_ovf    shared result bus and overflow flag
//   add_x1, add_x2      operands to the shared adder (registered)
//   add_y, add_ovf      result and overflow flag from the shared adder
//   busy                scheduler is not idle
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. req_ready may depend combinationally on req_valid; a requester
// holds its operands stable while valid and not yet accepted. resp_valid,
// resp_y and resp_ovf hold until the granted requester's resp_ready is seen.
module fadd_sched #(
  parameter int N   = 4,
  parameter int LAT = 0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [32*N-1:0] req_x1,
  input  logic [32*N-1:0] req_x2,
  input  logic [N-1:0]    req_sub,
  output logic [N-1:0]    resp_valid,
  input  logic [N-1:0]    resp_ready,
  output logic [31:0]     resp_y,
  output logic            resp_ovf,
  output logic [31:0]     add_x1,
  output logic [31:0]     add_x2,
  input  logic [31:0]     add_y,
  input  logic            add_ovf,
  output logic            busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (LAT > 0) ? $clog2(LAT + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_n;
  logic [PW-1:0] ptr, gnt;
  logic [CW-1:0] cnt;
  logic [31:0]   op1, op2, res;
  logic          ovf;

  // Grant search result
  logic          any;
  logic [PW-1:0] g;
  logic [31:0]   sel_x1, sel_x2;
  logic          sel_sub;

  // Search starts just after the last served requester so that every
  // continuously-valid requester is served within N operations.
  always_comb begin
    int idx;
    any     = 1'b0;
    g       = '0;
    sel_x1  = '0;
    sel_x2  = '0;
    sel_sub = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req_valid[idx]) begin
        any     = 1'b1;
        g       = PW'(idx);
        sel_x1  = req_x1[32*idx +: 32];
        sel_x2  = req_x2[32*idx +: 32];
        sel_sub = req_sub[idx];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (any) state_n = WAIT;
      WAIT:    if (cnt == '0) state_n = RESP;
      RESP:    if (resp_ready[gnt]) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      ptr   <= PW'(N - 1);
      gnt   <= '0;
      cnt   <= '0;
      op1   <= '0;
      op2   <= '0;
      res   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (any) begin
            op1 <= sel_x1;
            // Subtraction is a raw sign-bit flip of x2, NaN and zero included.
            op2 <= {sel_x2[31] ^ sel_sub, sel_x2[30:0]};
            gnt <= g;
            cnt <= CW'(LAT);
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            res <= add_y;
            ovf <= add_ovf;
          end
        end
        RESP: begin
          if (resp_ready[gnt]) ptr <= gnt;
        end
        default: ;
      endcase
    end
  end

  // Outputs are forced to their idle values while reset is held, even
  // before the reset edge has cleared the registers.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    if (rstn && state == IDLE && any) req_ready[g] = 1'b1;
    if (rstn && state == RESP) resp_valid[gnt] = 1'b1;
  end

  assign resp_y   = rstn ? res : 32'h0;
  assign resp_ovf = rstn ? ovf : 1'b0;
  assign add_x1   = rstn ? op1 : 32'h0;
  assign add_x2   = rstn ? op2 : 32'h0;
  assign busy     = rstn && (state != IDLE);

endmodule

// File: tb/tb_fadd_sched.sv
// Bench for fadd_sched: one instance with LAT=0 (combinational stub adder)
// and one with LAT=3 (stub adder followed by a 3-stage delay line).
module tb_fadd_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Stub adder: a table of known sums, anything else yields a marker value.
  function automatic logic [32:0] stub(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h40000000}: stub = {1'b0, 32'h40400000}; // 1+2
      {32'h40400000, 32'hBF800000}: stub = {1'b0, 32'h40000000}; // 3-1
      {32'h7F7FFFFF, 32'h7F7FFFFF}: stub = {1'b1, 32'h7F800000}; // max+max
      {32'h40000000, 32'h40000000}: stub = {1'b0, 32'h40800000}; // 2+2
      {32'h40800000, 32'hC0000000}: stub = {1'b0, 32'h40000000}; // 4-2
      default:                      stub = {1'b0, 32'hDEADBEEF};
    endcase
  endfunction

  // Instance with LAT=0
  logic         rstn;
  logic [3:0]   req_valid, req_ready, req_sub, resp_valid, resp_ready;
  logic [127:0] req_x1, req_x2;
  logic [31:0]  resp_y, add_x1, add_x2, add_y;
  logic         resp_ovf, add_ovf, busy;

  assign {add_ovf, add_y} = stub(add_x1, add_x2);

  fadd_sched #(.N(4), .LAT(0)) dut0 (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x1(req_x1), .req_x2(req_x2), .req_sub(req_sub),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_y(resp_y), .resp_ovf(resp_ovf),
    .add_x1(add_x1), .add_x2(add_x2), .add_y(add_y), .add_ovf(add_ovf),
    .busy(busy)
  );

  // Instance with LAT=3
  logic         b_rstn;
  logic [3:0]   b_req_valid, b_req_ready, b_req_sub, b_resp_valid, b_resp_ready;
  logic [127:0] b_req_x1, b_req_x2;
  logic [31:0]  b_resp_y, b_add_x1, b_add_x2, b_add_y;
  logic         b_resp_ovf, b_add_ovf, b_busy;
  logic [32:0]  pipe [0:2];

  always @(posedge clk) begin
    pipe[0] <= stub(b_add_x1, b_add_x2);
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
  end
  assign {b_add_ovf, b_add_y} = pipe[2];

  fadd_sched #(.N(4), .LAT(3)) dut3 (
    .clk(clk), .rstn(b_rstn),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_x1(b_req_x1), .req_x2(b_req_x2), .req_sub(b_req_sub),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_y(b_resp_y), .resp_ovf(b_resp_ovf),
    .add_x1(b_add_x1), .add_x2(b_add_x2), .add_y(b_add_y), .add_ovf(b_add_ovf),
    .busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [31:0] x1, input logic [31:0] x2, input logic sub);
    req_x1[32*i +: 32] = x1;
    req_x2[32*i +: 32] = x2;
    req_sub[i]         = sub;
    req_valid[i]       = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; b_rstn = 1'b0;
    req_valid = 4'b1111; req_sub = '0; req_x1 = '0; req_x2 = '0; resp_ready = '0;
    b_req_valid = '0; b_req_sub = '0; b_req_x1 = '0; b_req_x2 = '0; b_resp_ready = '0;

    // Reset: outputs idle even with every request valid
    repeat (3) tick();
    #1;
    check("rst_req_ready", req_ready, 4'b0000);
    check("rst_resp_valid", resp_valid, 4'b0000);
    check("rst_resp_y", resp_y, 32'h0);
    check("rst_resp_ovf", resp_ovf, 1'b0);
    check("rst_add_x1", add_x1, 32'h0);
    check("rst_add_x2", add_x2, 32'h0);
    check("rst_busy", busy, 1'b0);

    // Single add from requester 2
    tick();
    rstn = 1'b1; b_rstn = 1'b1; req_valid = '0;
    set_req(2, 32'h3F800000, 32'h40000000, 1'b0);
    #1 check("add_ready", req_ready, 4'b0100);
    tick(); req_valid = '0;
    #1;
    check("add_busy", busy, 1'b1);
    check("add_x1", add_x1, 32'h3F800000);
    check("add_x2", add_x2, 32'h40000000);
    check("add_no_resp_yet", resp_valid, 4'b0000);
    tick();
    #1;
    check("add_resp_valid", resp_valid, 4'b0100);
    check("add_resp_y", resp_y, 32'h40400000);
    check("add_resp_ovf", resp_ovf, 1'b0);
    resp_ready = 4'b0100;
    tick();
    #1;
    check("add_done_valid", resp_valid, 4'b0000);
    check("add_done_busy", busy, 1'b0);

    // Subtract from requester 0 (ptr=2, search wraps to 0)
    resp_ready = 4'b1111;
    set_req(0, 32'h40400000, 32'h3F800000, 1'b1);
    #1 check("sub_ready", req_ready, 4'b0001);
    tick(); req_valid = '0;
    #1;
    check("sub_add_x1", add_x1, 32'h40400000);
    check("sub_add_x2", add_x2, 32'hBF800000);
    tick();
    #1;
    check("sub_resp_valid", resp_valid, 4'b0001);
    check("sub_resp_y", resp_y, 32'h40000000);

    // Backpressure on requester 1 while requester 3 waits
    tick();
    resp_ready = 4'b1101;
    set_req(1, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0);
    set_req(3, 32'h40000000, 32'h40000000, 1'b0);
    #1 check("bp_ready", req_ready, 4'b0010);
    tick(); req_valid = 4'b1000;
    #1 check("bp_wait_ready", req_ready, 4'b0000);
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      #1;
      check("bp_hold_valid", resp_valid, 4'b0010);
      check("bp_hold_y", resp_y, 32'h7F800000);
      check("bp_hold_ovf", resp_ovf, 1'b1);
      check("bp_hold_ready", req_ready, 4'b0000);
    end
    tick(); resp_ready = 4'b1111;
    #1 check("bp_release_valid", resp_valid, 4'b0010);
    tick();
    #1;
    check("bp_next_grant", req_ready, 4'b1000);
    check("bp_next_resp_off", resp_valid, 4'b0000);
    tick(); req_valid = '0;
    tick();
    #1;
    check("bp_r3_valid", resp_valid, 4'b1000);
    check("bp_r3_y", resp_y, 32'h40800000);
    check("bp_r3_ovf", resp_ovf, 1'b0);
    tick();

    // Fairness: all requesters valid, ptr=3, expect 0,1,2,3,0
    for (int i = 0; i < 4; i++) set_req(i, 32'h3F800000, 32'h40000000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #1 check("fair_grant", req_ready, 32'(4'b0001 << (k % 4)));
      tick();
      #1 check("fair_wait_ready", req_ready, 4'b0000);
      tick();
      #1;
      check("fair_resp_valid", resp_valid, 32'(4'b0001 << (k % 4)));
      check("fair_resp_y", resp_y, 32'h40400000);
      check("fair_resp_ready", req_ready, 4'b0000);
      tick();
    end
    req_valid = '0;

    // Reset during WAIT (ptr=0, so requester 2 wins)
    set_req(2, 32'h3F800000, 32'h40000000, 1'b0);
    #1 check("rmid_ready", req_ready, 4'b0100);
    tick(); req_valid = '0; rstn = 1'b0;
    tick(); rstn = 1'b1;
    #1;
    check("rmid_busy", busy, 1'b0);
    check("rmid_resp_valid", resp_valid, 4'b0000);
    check("rmid_add_x1", add_x1, 32'h0);
    req_valid = 4'b1111;
    #1 check("rmid_first_grant", req_ready, 4'b0001);
    tick(); req_valid = '0;
    tick();
    tick();

    // LAT=3 instance: requester 1 computes 4 - 2
    b_resp_ready = 4'b0010;
    b_req_x1[63:32] = 32'h40800000;
    b_req_x2[63:32] = 32'h40000000;
    b_req_sub[1] = 1'b1;
    b_req_valid[1] = 1'b1;
    #1 check("lat_ready", b_req_ready, 4'b0010);
    tick(); b_req_valid = '0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      check("lat_no_resp", b_resp_valid, 4'b0000);
      check("lat_busy", b_busy, 1'b1);
      if (c == 4) check("lat_add_x2", b_add_x2, 32'hC0000000);
      tick();
    end
    #1;
    check("lat_resp_valid", b_resp_valid, 4'b0010);
    check("lat_resp_y", b_resp_y, 32'h40000000);
    check("lat_resp_ovf", b_resp_ovf, 1'b0);
    tick();
    #1 check("lat_idle", b_busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fadd_sched.md
# fadd_sched

Round-robin scheduler that shares one single-precision adder instance (`fadd`, 32-bit IEEE-754, combinational or externally pipelined) among N requesters. Each requester issues an add or subtract with a valid/ready handshake. The scheduler grants one requester, registers its operands, and drives them to the adder. It waits a fixed adder latency, captures the sum and returns it on that requester's response channel. Only one operation is in flight at a time. The block sits between the compute clients and the shared adder.

## Interface
Parameters:
- `N`, 4: number of requesters (2..16).
- `LAT`, 0: adder pipeline depth in cycles. Use 0 for the combinational `fadd`.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `rstn`  in  1: reset, synchronous, active-low.
- `req_valid`  in  N: request present, one bit per requester.
- `req_ready`  out  N: request accepted this cycle.
- `req_x1`  in  32N: operand 1 of requester i, in bits [32i+31:32i].
- `req_x2`  in  32N: operand 2, same packing.
- `req_sub`  in  N: 1 selects x1 − x2, 0 selects x1 + x2.
- `resp_valid`  out  N: result valid, for the granted requester only.
- `resp_ready`  in  N: requester consumes the result.
- `resp_y`  out  32: result, shared by all requesters and meaningful only where resp_valid is set.
- `resp_ovf`  out  1: adder ovf flag captured with the result.
- `add_x1`, `add_x2`  out  32: operands driven to the shared adder.
- `add_y`  in  32: adder result.
- `add_ovf`  in  1: adder overflow flag.
- `busy`  out  1: state ≠ IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - If any req_valid bit is set, the grant g is the first set bit searching from `ptr+1` upward, wrapping modulo N.
  - `req_ready[g]` is asserted combinationally. All other req_ready bits are 0.
  - On the edge, the block registers `op1=req_x1[g]`, `op2={req_x2[g][31]^req_sub[g], req_x2[g][30:0]}` and `gnt=g`, loads `cnt=LAT`, and goes to WAIT.
- **WAIT**
  - `add_x1=op1` and `add_x2=op2`, both registered and stable for the whole operation.
  - If `cnt≠0`, decrement cnt.
  - If `cnt==0`, capture `add_y` into `res` and `add_ovf` into `ovf`, then go to RESP.
- **RESP**
  - `resp_valid[gnt]=1`, `resp_y=res`, `resp_ovf=ovf`.
  - On `resp_ready[gnt]`, set `ptr←gnt` and return to IDLE.
  - resp_ready bits of non-granted requesters are ignored.
- No new request is accepted in the cycle a response completes. IDLE is always visited for at least one cycle.
- Round-robin guarantees each continuously-valid requester is served within N operations.
- The counter width is `$clog2(LAT+1)`, with a minimum of 1.
- Sign flip for subtraction is applied to the raw bit pattern. It applies to NaN and zero too; no special casing.

## Timing
- Reset values: state=IDLE, `ptr=N-1` (requester 0 wins first), cnt=0, op1=op2=res=0, ovf=0.
- Outputs while in reset: req_ready=0, resp_valid=0, resp_y=0, resp_ovf=0, add_x1=add_x2=0, busy=0.
- Acceptance in cycle T gives WAIT in cycles T+1..T+1+LAT. resp_valid rises in cycle T+LAT+2.
  - LAT=0: result visible 2 cycles after acceptance.
- Back-to-back throughput is one operation per LAT+3 cycles when resp_ready is held high.
- req_ready may depend combinationally on req_valid. req_valid must not depend on req_ready.
- A requester holds req_x1, req_x2 and req_sub stable while req_valid=1 and not yet accepted.
- resp_valid, resp_y and resp_ovf stay stable while stalled by resp_ready=0.
- Reset asserted in any state returns to the reset values on the next edge. An in-flight operation is dropped with no response and ptr resets.
- If req_valid bits drop in IDLE before acceptance, no grant occurs and ptr is unchanged.

## Test plan
- **Single add.** N=4, LAT=0. Requester 2 sends 0x3F800000 + 0x40000000, sub=0. Required: req_ready[2] in the same cycle, then resp_valid[2] 2 cycles later with resp_y=0x40400000 and resp_ovf=0.
- **Subtract.** Requester 0 sends 0x40400000 − 0x3F800000, sub=1. Required: add_x2=0xBF800000 during WAIT, and resp_y=0x40000000.
- **Fairness.** All four requesters hold valid continuously and resp_ready=1. Required: grant order 0,1,2,3,0, with an acceptance every 3 cycles.
- **Backpressure.** resp_ready[1]=0 for 5 cycles in RESP. Required: resp_valid[1] and resp_y hold, req_ready stays 0, and the next grant occurs 1 cycle after resp_ready rises.
- **Latency parameter.** LAT=3, stub adder with a 3-cycle delay. Required: resp_valid in cycle T+5, with the correct sum.
- **Reset mid-operation.** rstn=0 during WAIT. Required: the next cycle shows busy=0, resp_valid=0 and add_x1=0. The first post-reset grant goes to requester 0.
